// File: rtl/spi_digit_receiver_if.sv
// spi_digit_receiver_if
//   Bundles the MCU-facing SPI pins, the vblank tick and the display-side
//   outputs of spi_digit_receiver.
//   master modport: MCU / bench side (drives sck, sdi, csN, frameTick).
//   slave  modport: the receiver (drives digit, digitEn, digitChanged,
//                   errFlag and the fsm_state debug view).
//
// Transfer semantics: a transaction is one csN-low window. It is valid only
// if it carries exactly BITS rising sck edges and a legal byte; a valid byte
// is handed to the display either at the next frameTick (frame-synced build)
// or directly after the frame check. There is no back-pressure: the receiver
// is always ready, and digitChanged is a one-cycle strobe with no acknowledge.
interface spi_digit_receiver_if;
    logic       sck;
    logic       sdi;
    logic       csN;
    logic       frameTick;
    logic [3:0] digit;
    logic       digitEn;
    logic       digitChanged;
    logic       errFlag;
    logic [2:0] fsm_state;

    modport master (
        output sck, sdi, csN, frameTick,
        input  digit, digitEn, digitChanged, errFlag, fsm_state
    );

    modport slave (
        input  sck, sdi, csN, frameTick,
        output digit, digitEn, digitChanged, errFlag, fsm_state
    );
endinterface

// File: rtl/spi_digit_receiver.sv
// spi_digit_receiver
//   SPI slave (mode 0, MSB first) running in the pixClk domain. Oversamples
//   the asynchronous SCK/SDI/CSn pins, validates each 8-bit frame
//   ([7]=enable, [6:4]=reserved zero, [3:0]=digit) and drives the committed
//   digit/enable shown by the VGA digit display.
// Ports
//   pixClk  : pixel clock
//   reset   : asynchronous, active-high
//   bus     : spi_digit_receiver_if.slave (sck, sdi, csN, frameTick in;
//             digit, digitEn, digitChanged, errFlag, fsm_state out)
// Build option
//   DIGIT_FRAME_SYNC_EN : when defined, accepted bytes wait in a pending
//   register and commit on frameTick (tear-free). When undefined, frameTick
//   is ignored and accepted bytes go straight to the outputs.
module spi_digit_receiver #(
    parameter int BITS        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_DIGIT   = 9
) (
    input  logic                 pixClk,
    input  logic                 reset,
    spi_digit_receiver_if.slave  bus
);
    localparam int CNT_W    = $clog2(BITS + 1);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(BITS);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        SHIFT     = 3'd2,
        FULL      = 3'd3,
        CHECK     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BITS-1:0]        shift_q, shift_d;
    logic                   overrun_q, overrun_d;
    logic                   err_q, err_d;
    logic [4:0]             out_q, out_d;        // {enable, digit}
    logic                   changed_q, changed_d;
`ifdef DIGIT_FRAME_SYNC_EN
    logic [4:0]             pending_q, pending_d;
    logic                   pend_valid_q, pend_valid_d;
`else
    logic                   chg_pend_q, chg_pend_d;
    logic                   unused_frame_tick;
    assign unused_frame_tick = bus.frameTick;
`endif

    logic       sck_s, sdi_s, cs_s;
    logic       sck_rise, cs_rise, cs_fall;
    logic       frame_ok, accept;
    logic [4:0] new_val;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign new_val  = {shift_q[7], shift_q[3:0]};
    assign frame_ok = !overrun_q && (shift_q[6:4] == 3'b000)
                      && (int'(shift_q[3:0]) <= MAX_DIGIT);

    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], bus.csN};
        sck_prev_d = sck_s;
        cs_prev_d  = cs_s;
        // The synchronizers reset to idle values, so cs_s reads high until the
        // real pin level has propagated; WAIT_IDLE must not trust it earlier.
        settle_d   = (settle_q != SETTLE_MAX) ? settle_q + SETTLE_W'(1) : settle_q;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        overrun_d  = overrun_q;
        err_d      = err_q;
        accept     = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                if (settle_q == SETTLE_MAX && cs_s) state_d = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    overrun_d = 1'b0;
                end
            end
            SHIFT: begin
                // A same-cycle sck edge is counted before csN is looked at.
                if (sck_rise) begin
                    shift_d   = {shift_q[BITS-2:0], sdi_s};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                if (cs_rise) begin
                    if (bit_cnt_d == CNT_FULL) begin
                        state_d = CHECK;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (bit_cnt_d == CNT_FULL) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (sck_rise) overrun_d = 1'b1;
                if (cs_rise)  state_d   = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
                if (frame_ok) accept = 1'b1;
                else          err_d  = 1'b1;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        out_d     = out_q;
        changed_d = 1'b0;
`ifdef DIGIT_FRAME_SYNC_EN
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        if (bus.frameTick && pend_valid_q) begin
            out_d        = pending_q;
            pend_valid_d = 1'b0;
            changed_d    = (pending_q != out_q);
        end
        // Applied after the commit so a coinciding accept stays pending.
        if (accept) begin
            pending_d    = new_val;
            pend_valid_d = 1'b1;
        end
`else
        changed_d  = chg_pend_q;
        chg_pend_d = 1'b0;
        if (accept) begin
            out_d      = new_val;
            chg_pend_d = (new_val != out_q);
        end
`endif
    end

    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_IDLE;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            settle_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            overrun_q  <= 1'b0;
            err_q      <= 1'b0;
            out_q      <= '0;
            changed_q  <= 1'b0;
`ifdef DIGIT_FRAME_SYNC_EN
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
`else
            chg_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sck_sync_q <= sck_sync_d;
            sdi_sync_q <= sdi_sync_d;
            cs_sync_q  <= cs_sync_d;
            sck_prev_q <= sck_prev_d;
            cs_prev_q  <= cs_prev_d;
            settle_q   <= settle_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            overrun_q  <= overrun_d;
            err_q      <= err_d;
            out_q      <= out_d;
            changed_q  <= changed_d;
`ifdef DIGIT_FRAME_SYNC_EN
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
`else
            chg_pend_q <= chg_pend_d;
`endif
        end
    end

    assign bus.digit        = out_q[3:0];
    assign bus.digitEn      = out_q[4];
    assign bus.digitChanged = changed_q;
    assign bus.errFlag      = err_q;
    assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_spi_digit_receiver.sv
module tb_spi_digit_receiver;
    localparam bit SYNC_MODE =
`ifdef DIGIT_FRAME_SYNC_EN
        1'b1;
`else
        1'b0;
`endif

    logic pix_clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   chg_cnt = 0;
    int   chg_base;

    always #20 pix_clk = ~pix_clk;

    spi_digit_receiver_if bus_if();

    spi_digit_receiver dut (
        .pixClk (pix_clk),
        .reset  (reset),
        .bus    (bus_if)
    );

    // counts every cycle the change strobe is high
    always @(negedge pix_clk) begin
        if (bus_if.digitChanged === 1'b1) chg_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge pix_clk);
    endtask

    // n bits, MSB first, sck half period of 4 pixClk cycles
    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.sdi = bits[n-1-i];
            clks(4);
            bus_if.sck = 1'b1;
            clks(4);
            bus_if.sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] bits, input int n, input int post);
        bus_if.csN = 1'b0;
        clks(4);
        send_bits(bits, n);
        clks(4);
        bus_if.csN = 1'b1;
        clks(post);
    endtask

    task automatic send_byte(input logic [7:0] b);
        frame({8'h00, b}, 8, 8);
    endtask

    task automatic frame_tick();
        bus_if.frameTick = 1'b1;
        clks(1);
        bus_if.frameTick = 1'b0;
        clks(3);
    endtask

    initial begin
        bus_if.sck       = 1'b0;
        bus_if.sdi       = 1'b0;
        bus_if.csN       = 1'b1;
        bus_if.frameTick = 1'b0;
        reset            = 1'b1;
        clks(3);
        check_eq("rst_digit",   32'(bus_if.digit), 32'd0);
        check_eq("rst_en",      32'(bus_if.digitEn), 32'd0);
        check_eq("rst_changed", 32'(bus_if.digitChanged), 32'd0);
        check_eq("rst_err",     32'(bus_if.errFlag), 32'd0);
        reset = 1'b0;
        clks(6);
        check_eq("idle_state",  32'(bus_if.fsm_state), 32'd1);

        // 0x87: enable + digit 7
        chg_base = chg_cnt;
        send_byte(8'h87);
        check_eq("b87_pre_tick", 32'(bus_if.digit), SYNC_MODE ? 32'd0 : 32'd7);
        frame_tick();
        check_eq("b87_digit", 32'(bus_if.digit), 32'd7);
        check_eq("b87_en",    32'(bus_if.digitEn), 32'd1);
        check_eq("b87_err",   32'(bus_if.errFlag), 32'd0);
        check_eq("b87_chg",   32'(chg_cnt - chg_base), 32'd1);

        // 0x8A: digit 10 is illegal
        chg_base = chg_cnt;
        send_byte(8'h8A);
        frame_tick();
        check_eq("b8a_err",   32'(bus_if.errFlag), 32'd1);
        check_eq("b8a_digit", 32'(bus_if.digit), 32'd7);
        check_eq("b8a_en",    32'(bus_if.digitEn), 32'd1);
        check_eq("b8a_chg",   32'(chg_cnt - chg_base), 32'd0);

        // short frame: 5 edges, then a good 0x83
        frame(16'b10110, 5, 8);
        check_eq("short_err",   32'(bus_if.errFlag), 32'd1);
        check_eq("short_state", 32'(bus_if.fsm_state), 32'd1);
        chg_base = chg_cnt;
        send_byte(8'h83);
        frame_tick();
        check_eq("b83_digit", 32'(bus_if.digit), 32'd3);
        check_eq("b83_en",    32'(bus_if.digitEn), 32'd1);
        check_eq("b83_chg",   32'(chg_cnt - chg_base), 32'd1);

        // overrun: 9 edges (0x84 followed by a ninth bit)
        frame({7'd0, 8'h84, 1'b1}, 9, 8);
        frame_tick();
        check_eq("ovr_digit", 32'(bus_if.digit), 32'd3);
        check_eq("ovr_err",   32'(bus_if.errFlag), 32'd1);

        // two good bytes inside one frame: last one wins
        chg_base = chg_cnt;
        send_byte(8'h81);
        send_byte(8'h85);
        frame_tick();
        check_eq("last_digit", 32'(bus_if.digit), 32'd5);
        check_eq("last_en",    32'(bus_if.digitEn), 32'd1);
        check_eq("last_chg",   32'(chg_cnt - chg_base), SYNC_MODE ? 32'd1 : 32'd2);

        // reset in the middle of 0x86 with csN held low
        bus_if.csN = 1'b0;
        clks(4);
        send_bits(16'b1000, 4);
        reset = 1'b1;
        clks(3);
        check_eq("mid_rst_digit", 32'(bus_if.digit), 32'd0);
        check_eq("mid_rst_err",   32'(bus_if.errFlag), 32'd0);
        reset = 1'b0;
        chg_base = chg_cnt;
        send_bits(16'b0110, 4);
        clks(4);
        bus_if.csN = 1'b1;
        clks(8);
        frame_tick();
        check_eq("mid_ign_digit", 32'(bus_if.digit), 32'd0);
        check_eq("mid_ign_en",    32'(bus_if.digitEn), 32'd0);
        check_eq("mid_ign_err",   32'(bus_if.errFlag), 32'd0);
        check_eq("mid_ign_chg",   32'(chg_cnt - chg_base), 32'd0);

        // fresh 0x02 after the reset: digit 2, display disabled
        chg_base = chg_cnt;
        frame(16'h0002, 8, 5);
        check_eq("b02_fast_digit", 32'(bus_if.digit), SYNC_MODE ? 32'd0 : 32'd2);
        check_eq("b02_fast_en",    32'(bus_if.digitEn), 32'd0);
        frame_tick();
        check_eq("b02_digit", 32'(bus_if.digit), 32'd2);
        check_eq("b02_en",    32'(bus_if.digitEn), 32'd0);
        check_eq("b02_err",   32'(bus_if.errFlag), 32'd0);
        check_eq("b02_chg",   32'(chg_cnt - chg_base), 32'd1);

        // frameTick with nothing pending changes nothing
        chg_base = chg_cnt;
        frame_tick();
        check_eq("empty_tick_digit", 32'(bus_if.digit), 32'd2);
        check_eq("empty_tick_chg",   32'(chg_cnt - chg_base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case a task never returns
    initial begin
        #5ms;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
